// File: rtl/fwd_pkg.sv
// Shared types for the decode-stage forwarding and load-use hazard control.
package fwd_pkg;

   localparam int REG_W  = 5;
   localparam int ZR_IDX = 31;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_EX  = 2'b01,
      FWD_MEM = 2'b10,
      FWD_WB  = 2'b11
   } fwd_sel_t;

   typedef struct packed {
      logic             vld;
      logic [REG_W-1:0] rd;
      logic             wr;
      logic             ld;
   } fwd_entry_t;

   typedef enum logic {
      RUN      = 1'b0,
      LU_STALL = 1'b1
   } lu_state_t;

endpackage

// File: rtl/fwd_match.sv
// Compares one decode source register against the EX/MEM/WB destinations and
// picks the youngest producer; also flags a pending load in EX.
module fwd_match
   import fwd_pkg::*;
#(
   parameter int ZR = ZR_IDX
) (
   input  logic [REG_W-1:0] src,
   input  logic             src_used,
   input  fwd_entry_t       ex_e,
   input  fwd_entry_t       mem_e,
   input  fwd_entry_t       wb_e,
   output fwd_sel_t         sel,
   output logic             load_hit
);

   localparam logic [REG_W-1:0] ZR_REG = REG_W'(ZR);

   function automatic logic hit(input fwd_entry_t e, input logic [REG_W-1:0] s,
                                input logic used);
      return e.vld & e.wr & (e.rd == s) & (s != ZR_REG) & used;
   endfunction

   logic m_ex, m_mem, m_wb;
   logic unused_ld;

   assign m_ex      = hit(ex_e,  src, src_used);
   assign m_mem     = hit(mem_e, src, src_used);
   assign m_wb      = hit(wb_e,  src, src_used);
   assign load_hit  = m_ex & ex_e.ld;
   assign unused_ld = mem_e.ld ^ wb_e.ld;

   always_comb begin
      sel = FWD_RF;
      if (m_ex)       sel = FWD_EX;
      else if (m_mem) sel = FWD_MEM;
      else if (m_wb)  sel = FWD_WB;
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Operand forwarding select generation, single-bubble load-use stall and
// saturating stall-cycle counter for the 5-stage pipeline decode stage.
module fwd_hazard_ctrl #(
   parameter int REG_W  = fwd_pkg::REG_W,
   parameter int ZR_IDX = fwd_pkg::ZR_IDX,
   parameter int CNT_W  = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             dec_valid,
   input  logic [REG_W-1:0] dec_rn,
   input  logic             dec_rn_used,
   input  logic [REG_W-1:0] dec_rm,
   input  logic             dec_rm_used,
   input  logic [REG_W-1:0] dec_rd,
   input  logic             dec_rd_wr,
   input  logic             dec_is_load,
   input  logic             flush_ex,
   input  logic             mem_stall,
   output logic [1:0]       sel_a,
   output logic [1:0]       sel_b,
   output logic             stall_dec,
   output logic [CNT_W-1:0] stall_cnt
);

   import fwd_pkg::*;

   fwd_entry_t ex_p0, mem_p1, wb_p2;
   lu_state_t  state_q, state_d;
   fwd_sel_t   sel_a_m, sel_b_m;
   logic       hit_a, hit_b;
   logic       hazard;
   logic       issue;

   fwd_match #(.ZR(ZR_IDX)) u_match_a (
      .src      (dec_rn),
      .src_used (dec_rn_used),
      .ex_e     (ex_p0),
      .mem_e    (mem_p1),
      .wb_e     (wb_p2),
      .sel      (sel_a_m),
      .load_hit (hit_a)
   );

   fwd_match #(.ZR(ZR_IDX)) u_match_b (
      .src      (dec_rm),
      .src_used (dec_rm_used),
      .ex_e     (ex_p0),
      .mem_e    (mem_p1),
      .wb_e     (wb_p2),
      .sel      (sel_b_m),
      .load_hit (hit_b)
   );

   // In LU_STALL the load has moved on to MEM, so only RUN can raise a hazard.
   assign hazard    = dec_valid & (state_q == RUN) & (hit_a | hit_b);
   assign stall_dec = mem_stall | hazard;
   assign issue     = dec_valid & ~hazard & ~flush_ex;
   assign sel_a     = dec_valid ? sel_a_m : FWD_RF;
   assign sel_b     = dec_valid ? sel_b_m : FWD_RF;

   // ---- decode -> EX -> MEM -> WB tracking ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_p0  <= '0;
         mem_p1 <= '0;
         wb_p2  <= '0;
      end else if (!mem_stall) begin
         wb_p2  <= mem_p1;
         mem_p1 <= ex_p0;
         if (issue) begin
            ex_p0.vld <= 1'b1;
            ex_p0.rd  <= dec_rd;
            ex_p0.wr  <= dec_rd_wr;
            ex_p0.ld  <= dec_is_load;
         end else begin
            ex_p0 <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= RUN;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:      if (hazard && !mem_stall) state_d = LU_STALL;
         LU_STALL: if (!mem_stall)           state_d = RUN;
         default:  state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (stall_dec && (stall_cnt != {CNT_W{1'b1}}))
         stall_cnt <= stall_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: forwarding priority, load-use stall,
// freeze, async reset, flush, and counter saturation on a CNT_W=4 copy.
module tb_fwd_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        dec_valid;
   logic [4:0]  dec_rn, dec_rm, dec_rd;
   logic        dec_rn_used, dec_rm_used, dec_rd_wr, dec_is_load;
   logic        flush_ex, mem_stall;
   logic [1:0]  sel_a, sel_b;
   logic        stall_dec;
   logic [31:0] stall_cnt;

   logic        sat_stall;
   logic [1:0]  sat_sel_a, sat_sel_b;
   logic        sat_stall_dec;
   logic [3:0]  sat_cnt;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   fwd_hazard_ctrl dut (
      .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid),
      .dec_rn(dec_rn), .dec_rn_used(dec_rn_used),
      .dec_rm(dec_rm), .dec_rm_used(dec_rm_used),
      .dec_rd(dec_rd), .dec_rd_wr(dec_rd_wr), .dec_is_load(dec_is_load),
      .flush_ex(flush_ex), .mem_stall(mem_stall),
      .sel_a(sel_a), .sel_b(sel_b), .stall_dec(stall_dec), .stall_cnt(stall_cnt)
   );

   fwd_hazard_ctrl #(.CNT_W(4)) u_sat (
      .clk(clk), .rst_n(rst_n), .dec_valid(1'b0),
      .dec_rn(5'd0), .dec_rn_used(1'b0),
      .dec_rm(5'd0), .dec_rm_used(1'b0),
      .dec_rd(5'd0), .dec_rd_wr(1'b0), .dec_is_load(1'b0),
      .flush_ex(1'b0), .mem_stall(sat_stall),
      .sel_a(sat_sel_a), .sel_b(sat_sel_b), .stall_dec(sat_stall_dec), .stall_cnt(sat_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic v, input logic [4:0] rn, input logic rnu,
                        input logic [4:0] rm, input logic rmu,
                        input logic [4:0] rd, input logic wr, input logic ld);
      dec_valid = v; dec_rn = rn; dec_rn_used = rnu; dec_rm = rm; dec_rm_used = rmu;
      dec_rd = rd; dec_rd_wr = wr; dec_is_load = ld;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic nop;
      issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic drain;
      for (int i = 0; i < 3; i++) begin
         nop();
         tick();
      end
   endtask

   initial begin
      rst_n = 1'b0; flush_ex = 1'b0; mem_stall = 1'b0; sat_stall = 1'b0;
      issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
      #1;
      chk("reset sel_a", 32'(sel_a), 32'd0);
      chk("reset sel_b", 32'(sel_b), 32'd0);
      chk("reset stall_dec", 32'(stall_dec), 32'd0);
      chk("reset stall_cnt", stall_cnt, 32'd0);
      nop();
      tick();
      rst_n = 1'b1;
      tick();

      // ADD X1 then ADD X2,X1,X3
      issue(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 1'b0);
      chk("t1 producer stall", 32'(stall_dec), 32'd0);
      tick();
      issue(1'b1, 5'd1, 1'b1, 5'd3, 1'b1, 5'd2, 1'b1, 1'b0);
      chk("t1 sel_a", 32'(sel_a), 32'd1);
      chk("t1 sel_b", 32'(sel_b), 32'd0);
      chk("t1 stall", 32'(stall_dec), 32'd0);
      tick();
      drain();

      // LDUR X4 then SUB X5,X4,X4
      issue(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
      tick();
      issue(1'b1, 5'd4, 1'b1, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0);
      chk("t2 hazard stall", 32'(stall_dec), 32'd1);
      tick();
      chk("t2 sel_a", 32'(sel_a), 32'd2);
      chk("t2 sel_b", 32'(sel_b), 32'd2);
      chk("t2 stall released", 32'(stall_dec), 32'd0);
      chk("t2 stall_cnt", stall_cnt, 32'd1);
      tick();
      drain();

      // XZR is never forwarded and never a hazard
      issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd31, 1'b1, 1'b1);
      tick();
      issue(1'b1, 5'd31, 1'b1, 5'd31, 1'b1, 5'd6, 1'b1, 1'b0);
      chk("t3 sel_a", 32'(sel_a), 32'd0);
      chk("t3 sel_b", 32'(sel_b), 32'd0);
      chk("t3 stall", 32'(stall_dec), 32'd0);
      tick();
      drain();

      // X7 producer ageing through EX, MEM, WB; consumers write nothing
      issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
      tick();
      issue(1'b1, 5'd0, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
      chk("t4 ex sel_b", 32'(sel_b), 32'd1);
      chk("t4 rf sel_a", 32'(sel_a), 32'd0);
      tick();
      chk("t4 mem sel_b", 32'(sel_b), 32'd2);
      tick();
      chk("t4 wb sel_b", 32'(sel_b), 32'd3);
      tick();
      chk("t4 retired sel_b", 32'(sel_b), 32'd0);
      drain();

      // X7 in both EX and MEM: youngest wins
      issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
      tick();
      issue(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
      tick();
      issue(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
      chk("t4 youngest sel_a", 32'(sel_a), 32'd1);
      tick();
      drain();

      // Freeze for 3 cycles during a load-use hazard
      issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1);
      tick();
      issue(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0);
      mem_stall = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("t5 frozen stall", 32'(stall_dec), 32'd1);
         tick();
      end
      chk("t5 cnt after freeze", stall_cnt, 32'd4);
      mem_stall = 1'b0;
      #1;
      chk("t5 hazard after release", 32'(stall_dec), 32'd1);
      tick();
      chk("t5 resolved sel_a", 32'(sel_a), 32'd2);
      chk("t5 resolved stall", 32'(stall_dec), 32'd0);
      chk("t5 cnt", stall_cnt, 32'd5);
      tick();
      drain();

      // Async reset while in LU_STALL
      issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1);
      tick();
      issue(1'b1, 5'd12, 1'b1, 5'd12, 1'b1, 5'd13, 1'b1, 1'b0);
      chk("t6 hazard", 32'(stall_dec), 32'd1);
      tick();
      chk("t6 cnt before reset", stall_cnt, 32'd6);
      rst_n = 1'b0;
      #1;
      chk("t6 reset sel_a", 32'(sel_a), 32'd0);
      chk("t6 reset sel_b", 32'(sel_b), 32'd0);
      chk("t6 reset stall", 32'(stall_dec), 32'd0);
      chk("t6 reset cnt", stall_cnt, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("t6 post-reset stall", 32'(stall_dec), 32'd0);
      tick();
      chk("t6 post-reset cnt", stall_cnt, 32'd0);
      drain();

      // flush_ex together with a hazard gives a single bubble
      issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd14, 1'b1, 1'b1);
      tick();
      issue(1'b1, 5'd14, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      flush_ex = 1'b1;
      #1;
      chk("t7 hazard with flush", 32'(stall_dec), 32'd1);
      tick();
      flush_ex = 1'b0;
      #1;
      chk("t7 sel_a mem", 32'(sel_a), 32'd2);
      chk("t7 stall released", 32'(stall_dec), 32'd0);
      chk("t7 cnt", stall_cnt, 32'd1);
      tick();
      chk("t7 single bubble sel_a", 32'(sel_a), 32'd3);
      chk("t7 no extra stall", 32'(stall_dec), 32'd0);
      tick();
      drain();

      // Counter saturation on the CNT_W=4 instance
      chk("sat start", 32'(sat_cnt), 32'd0);
      sat_stall = 1'b1;
      #1;
      chk("sat stall_dec", 32'(sat_stall_dec), 32'd1);
      for (int i = 0; i < 14; i++) tick();
      chk("sat cnt 14", 32'(sat_cnt), 32'd14);
      tick();
      chk("sat cnt 15", 32'(sat_cnt), 32'd15);
      for (int i = 0; i < 5; i++) tick();
      chk("sat cnt held", 32'(sat_cnt), 32'd15);
      sat_stall = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
